// File: rtl/event_timestamp_fifo.sv
// Captures the free-running counter on edges of an asynchronous event line and
// queues the timestamps in a first-word-fall-through FIFO with overflow tracking.
module event_timestamp_fifo #(
  parameter int CNT_W       = 42,
  parameter int DEPTH_LOG2  = 4,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_MODE   = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [CNT_W-1:0]      counter_in,
  input  logic                  event_in,
  input  logic                  ts_ready,
  input  logic                  clear_overflow,
  output logic [CNT_W-1:0]      ts_data,
  output logic                  ts_valid,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  overflow,
  output logic [7:0]            drop_count
);

  localparam int                  DEPTH      = 1 << DEPTH_LOG2;
  localparam logic [1:0]          MODE       = 2'(EDGE_MODE);
  localparam logic [2:0]          PRIME_DONE = 3'(SYNC_STAGES + 1);
  localparam logic [DEPTH_LOG2:0] FULL_LEVEL = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0] LVL_ONE    = (DEPTH_LOG2 + 1)'(1'b1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1'b1);

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   s_d_r;
  logic [2:0]             prime_r;
  logic [CNT_W-1:0]       mem_r [DEPTH];
  logic [DEPTH_LOG2-1:0]  wr_ptr_r;
  logic [DEPTH_LOG2-1:0]  rd_ptr_r;
  logic [DEPTH_LOG2:0]    level_r;
  logic                   ts_valid_r;
  logic [CNT_W-1:0]       ts_data_r;
  logic                   overflow_r;
  logic [7:0]             drop_count_r;

  logic                   s_s;
  logic                   rise_s;
  logic                   fall_s;
  logic                   event_s;
  logic                   push_s;
  logic                   pop_s;
  logic                   full_s;
  logic                   wr_en_s;
  logic                   drop_s;
  logic [DEPTH_LOG2-1:0]  rd_next_s;
  logic [DEPTH_LOG2:0]    level_next_s;
  logic [CNT_W-1:0]       head_next_s;
  logic                   overflow_next_s;
  logic [7:0]             drop_next_s;

  assign s_s    = sync_r[SYNC_STAGES-1];
  assign rise_s = s_s & ~s_d_r;
  assign fall_s = ~s_s & s_d_r;

  // Select which synchronized edges count as events.
  always_comb begin
    event_s = 1'b0;
    case (MODE)
      2'd0:    event_s = rise_s;
      2'd1:    event_s = fall_s;
      2'd2:    event_s = rise_s | fall_s;
      default: event_s = rise_s;
    endcase
  end

  // Detection stays off until the synchronizer has flushed its reset contents.
  assign push_s    = event_s & (prime_r == PRIME_DONE);
  assign pop_s     = ts_valid_r & ts_ready;
  assign full_s    = (level_r == FULL_LEVEL);
  assign wr_en_s   = push_s & (~full_s | pop_s);
  assign drop_s    = push_s & full_s & ~pop_s;
  assign rd_next_s = pop_s ? (rd_ptr_r + PTR_ONE) : rd_ptr_r;

  // Occupancy follows accepted writes and pops.
  always_comb begin
    level_next_s = level_r;
    case ({wr_en_s, pop_s})
      2'b10:   level_next_s = level_r + LVL_ONE;
      2'b01:   level_next_s = level_r - LVL_ONE;
      default: level_next_s = level_r;
    endcase
  end

  // Next head: the incoming word when it lands on the new read slot, else memory.
  always_comb begin
    if (wr_en_s && (wr_ptr_r == rd_next_s)) begin
      head_next_s = counter_in;
    end else begin
      head_next_s = mem_r[rd_next_s];
    end
  end

  // A drop in the same cycle as a clear leaves a count of one.
  always_comb begin
    if (drop_s) begin
      overflow_next_s = 1'b1;
      if (clear_overflow) begin
        drop_next_s = 8'd1;
      end else if (drop_count_r != 8'hFF) begin
        drop_next_s = drop_count_r + 8'd1;
      end else begin
        drop_next_s = drop_count_r;
      end
    end else if (clear_overflow) begin
      overflow_next_s = 1'b0;
      drop_next_s     = 8'd0;
    end else begin
      overflow_next_s = overflow_r;
      drop_next_s     = drop_count_r;
    end
  end

  // Storage array; contents are discarded logically by resetting pointers.
  always_ff @(posedge clk) begin
    if (rst && wr_en_s) begin
      mem_r[wr_ptr_r] <= counter_in;
    end
  end

  // Synchronizer, prime counter, pointers and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_r       <= '0;
      s_d_r        <= 1'b0;
      prime_r      <= 3'd0;
      wr_ptr_r     <= '0;
      rd_ptr_r     <= '0;
      level_r      <= '0;
      ts_valid_r   <= 1'b0;
      ts_data_r    <= '0;
      overflow_r   <= 1'b0;
      drop_count_r <= 8'd0;
    end else begin
      sync_r       <= {sync_r[SYNC_STAGES-2:0], event_in};
      s_d_r        <= s_s;
      prime_r      <= (prime_r == PRIME_DONE) ? prime_r : (prime_r + 3'd1);
      wr_ptr_r     <= wr_en_s ? (wr_ptr_r + PTR_ONE) : wr_ptr_r;
      rd_ptr_r     <= rd_next_s;
      level_r      <= level_next_s;
      ts_valid_r   <= |level_next_s;
      ts_data_r    <= head_next_s;
      overflow_r   <= overflow_next_s;
      drop_count_r <= drop_next_s;
    end
  end

  assign ts_data    = ts_data_r;
  assign ts_valid   = ts_valid_r;
  assign level      = level_r;
  assign overflow   = overflow_r;
  assign drop_count = drop_count_r;

endmodule

// File: tb/tb_event_timestamp_fifo.sv
// Bench for event_timestamp_fifo: rising-edge and both-edge instances share the
// stimulus and are compared against a queue-based model plus directed vectors.
module tb_event_timestamp_fifo;

  localparam int CNT_W = 42;
  localparam int DL    = 4;
  localparam int SS    = 2;
  localparam int DEPTH = 16;

  typedef logic [CNT_W-1:0] ts_t;

  typedef struct {
    logic      r, e, rdy, clr;
    logic      ev;
    logic      chkd;
    logic [DL:0] el;
    ts_t       ed;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, event_in, ts_ready, clear_overflow;
  ts_t  counter_in;

  logic [1:0][CNT_W-1:0] d_data;
  logic [1:0]            d_valid;
  logic [1:0][DL:0]      d_level;
  logic [1:0]            d_ovf;
  logic [1:0][7:0]       d_drop;

  event_timestamp_fifo #(.CNT_W(CNT_W), .DEPTH_LOG2(DL), .SYNC_STAGES(SS), .EDGE_MODE(0)) dut0 (
    .clk(clk), .rst(rst), .counter_in(counter_in), .event_in(event_in),
    .ts_ready(ts_ready), .clear_overflow(clear_overflow),
    .ts_data(d_data[0]), .ts_valid(d_valid[0]), .level(d_level[0]),
    .overflow(d_ovf[0]), .drop_count(d_drop[0]));

  event_timestamp_fifo #(.CNT_W(CNT_W), .DEPTH_LOG2(DL), .SYNC_STAGES(SS), .EDGE_MODE(2)) dut1 (
    .clk(clk), .rst(rst), .counter_in(counter_in), .event_in(event_in),
    .ts_ready(ts_ready), .clear_overflow(clear_overflow),
    .ts_data(d_data[1]), .ts_valid(d_valid[1]), .level(d_level[1]),
    .overflow(d_ovf[1]), .drop_count(d_drop[1]));

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: per-instance queue, sampled-event history, prime count.
  ts_t  mq [2][$];
  logic hist [$];
  int   prime_n;
  logic m_ovf [2];
  int   m_drop [2];
  int   modes [2] = '{0, 2};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    for (int i = 0; i <= SS; i++) hist.push_back(1'b0);
    prime_n = 0;
    for (int m = 0; m < 2; m++) begin
      mq[m].delete();
      m_ovf[m]  = 1'b0;
      m_drop[m] = 0;
    end
  endtask

  task automatic model_edge();
    logic s, sd, ev, pop, drop;
    if (!rst) begin
      model_reset();
    end else begin
      s  = hist[SS-1];
      sd = hist[SS];
      for (int m = 0; m < 2; m++) begin
        ev = (prime_n >= SS + 1) &&
             ((modes[m] == 0) ? (s && !sd) : (s != sd));
        pop  = (mq[m].size() > 0) && ts_ready;
        drop = ev && (mq[m].size() == DEPTH) && !pop;
        if (pop) void'(mq[m].pop_front());
        if (ev && !drop) mq[m].push_back(counter_in);
        if (clear_overflow) begin
          m_ovf[m]  = 1'b0;
          m_drop[m] = 0;
        end
        if (drop) begin
          m_ovf[m] = 1'b1;
          if (m_drop[m] < 255) m_drop[m]++;
        end
      end
      hist.push_front(event_in);
      void'(hist.pop_back());
      if (prime_n < SS + 1) prime_n++;
    end
  endtask

  task automatic model_check();
    for (int m = 0; m < 2; m++) begin
      chk($sformatf("m%0d_valid", m), 64'(d_valid[m]), 64'(mq[m].size() > 0));
      chk($sformatf("m%0d_level", m), 64'(d_level[m]), 64'(mq[m].size()));
      chk($sformatf("m%0d_overflow", m), 64'(d_ovf[m]), 64'(m_ovf[m]));
      chk($sformatf("m%0d_drop", m), 64'(d_drop[m]), 64'(m_drop[m]));
      if (mq[m].size() > 0) chk($sformatf("m%0d_data", m), 64'(d_data[m]), 64'(mq[m][0]));
    end
  endtask

  task automatic step(input logic r, input logic e, input logic rdy, input logic clr);
    rst = r; event_in = e; ts_ready = rdy; clear_overflow = clr;
    @(posedge clk);
    model_edge();
    #1;
    counter_in = counter_in + 42'd1;
    model_check();
  endtask

  task automatic pulses(input int n, input logic rdy);
    for (int i = 0; i < n; i++) begin
      step(1'b1, 1'b1, rdy, 1'b0);
      step(1'b1, 1'b1, rdy, 1'b0);
      step(1'b1, 1'b0, rdy, 1'b0);
      step(1'b1, 1'b0, rdy, 1'b0);
    end
  endtask

  task automatic idle(input int n, input logic e, input logic rdy);
    for (int i = 0; i < n; i++) step(1'b1, e, rdy, 1'b0);
  endtask

  vec_t tbl [$];
  ts_t  first_ts, new_ts, c;

  initial begin
    rst = 1'b0; event_in = 1'b0; ts_ready = 1'b0; clear_overflow = 1'b0;
    counter_in = 42'd0;
    model_reset();

    // Reset with event high, prime interval, then a single rising capture.
    for (int i = 0; i < 3; i++)  tbl.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 42'd0});
    for (int i = 0; i < 20; i++) tbl.push_back('{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 42'd0});
    for (int i = 0; i < 4; i++)  tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 42'd0});
    tbl.push_back('{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 42'd0});
    tbl.push_back('{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 42'd0});
    tbl.push_back('{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 5'd1, 42'd1001});
    tbl.push_back('{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 42'd0});
    tbl.push_back('{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 42'd0});

    // Counter reads 999 before the edge that first samples the event high.
    counter_in = 42'd972;
    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].r, tbl[i].e, tbl[i].rdy, tbl[i].clr);
      chk($sformatf("tbl%0d_valid", i), 64'(d_valid[0]), 64'(tbl[i].ev));
      chk($sformatf("tbl%0d_level", i), 64'(d_level[0]), 64'(tbl[i].el));
      chk($sformatf("tbl%0d_overflow", i), 64'(d_ovf[0]), 64'd0);
      if (tbl[i].chkd) chk($sformatf("tbl%0d_data", i), 64'(d_data[0]), 64'(tbl[i].ed));
    end

    // Fill to full under backpressure, then overflow by three.
    idle(6, 1'b0, 1'b1);
    first_ts = counter_in + 42'd2;
    pulses(16, 1'b0);
    chk("fill_level", 64'(d_level[0]), 64'd16);
    chk("fill_overflow", 64'(d_ovf[0]), 64'd0);
    pulses(3, 1'b0);
    chk("ovf_flag", 64'(d_ovf[0]), 64'd1);
    chk("ovf_drops", 64'(d_drop[0]), 64'd3);
    chk("ovf_head", 64'(d_data[0]), 64'(first_ts));

    // Push coinciding with a pop while full is accepted.
    new_ts = counter_in + 42'd2;
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    chk("fullpp_level", 64'(d_level[0]), 64'd16);
    chk("fullpp_drops", 64'(d_drop[0]), 64'd3);

    // Clear in the same cycle as a drop: the drop wins.
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    chk("clrdrop_ovf", 64'(d_ovf[0]), 64'd1);
    chk("clrdrop_drops", 64'(d_drop[0]), 64'd1);

    // Drain: entries two..sixteen of the fill, then the accepted push.
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("drain%0d", k), 64'(d_data[0]),
          (k < 15) ? 64'(first_ts + 42'(4 * (k + 1))) : 64'(new_ts));
      step(1'b1, 1'b0, 1'b1, 1'b0);
    end
    chk("drain_level", 64'(d_level[0]), 64'd0);
    idle(4, 1'b0, 1'b1);

    // Both-edge instance: 10-cycle square wave for three periods.
    c = counter_in;
    for (int p = 0; p < 3; p++) begin
      idle(5, 1'b1, 1'b0);
      idle(5, 1'b0, 1'b0);
    end
    idle(4, 1'b0, 1'b0);
    chk("both_level", 64'(d_level[1]), 64'd6);
    chk("rise_level", 64'(d_level[0]), 64'd3);
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("both_ts%0d", k), 64'(d_data[1]), 64'(c + 42'd2 + 42'(5 * k)));
      step(1'b1, 1'b0, 1'b1, 1'b0);
    end
    idle(4, 1'b0, 1'b1);

    // Mid-stream reset discards entries; capture returns only after priming.
    pulses(5, 1'b0);
    idle(2, 1'b0, 1'b0);
    chk("pre_rst_level", 64'(d_level[0]), 64'd5);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    chk("rst_level", 64'(d_level[0]), 64'd0);
    chk("rst_valid", 64'(d_valid[0]), 64'd0);
    chk("rst_drops", 64'(d_drop[0]), 64'd0);
    idle(6, 1'b1, 1'b0);
    chk("prime_level", 64'(d_level[0]), 64'd0);
    idle(2, 1'b0, 1'b0);
    idle(3, 1'b1, 1'b0);
    chk("resume_level", 64'(d_level[0]), 64'd1);

    // Randomized traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      step(($urandom_range(0, 299) != 0),
           ($urandom_range(0, 2) == 0) ? ~event_in : event_in,
           (i < 750) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 1) == 0),
           ($urandom_range(0, 39) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/event_timestamp_fifo.md
Name: event_timestamp_fifo

Overview:
Downstream consumer of the free-running 42-bit system counter. Detects edges on an asynchronous event input and captures the counter value at each detected edge. Queues the captured timestamps in a small first-word-fall-through FIFO and presents them on a valid/ready stream. Overflow is tracked with a sticky flag and a drop counter. The stream output feeds the host readout / UART framer stage.

Parameters:
CNT_W, 42, width of counter_in and ts_data
DEPTH_LOG2, 4, FIFO depth = 2**DEPTH_LOG2 entries (default 16)
SYNC_STAGES, 2, synchronizer flops on event_in, legal range 2..4
EDGE_MODE, 0, 0 = rising edges, 1 = falling edges, 2 = both edges

Ports:
clk  input  1  system clock; counter_in is synchronous to it
rst  input  1  synchronous, active-low reset
counter_in  input  CNT_W  free-running counter value
event_in  input  1  asynchronous event line
ts_ready  input  1  downstream accepts the head entry
clear_overflow  input  1  single-cycle pulse; clears overflow and drop_count
ts_data  output  CNT_W  head-of-FIFO timestamp
ts_valid  output  1  FIFO is non-empty; ts_data is valid
level  output  DEPTH_LOG2+1  current occupancy, 0..2**DEPTH_LOG2
overflow  output  1  sticky: at least one event was dropped
drop_count  output  8  number of dropped events, saturates at 255

Behaviour:
- Reset (rst=0 at a clk edge):
  - Sync chain, edge-delay register, FIFO pointers, level, overflow and drop_count all go to 0.
  - ts_valid=0, ts_data=0.
  - Reset applied mid-operation discards all queued entries.
- Prime interval:
  - Edge detection is disabled for SYNC_STAGES+1 cycles after rst deasserts. An internal prime counter controls this.
  - An event_in held at a constant level through reset therefore produces no event.
- Synchronizer: event_in passes through SYNC_STAGES flops to give s; s is registered into s_d.
- Edge detect: rise = s & ~s_d; fall = ~s & s_d. EDGE_MODE selects which of these is counted as an event.
- Capture:
  - In the detect cycle, counter_in for that same cycle is written into the FIFO at the next clk edge.
  - Latency with SYNC_STAGES=2: event_in first sampled high at edge 0 → detect cycle between edges 1 and 2 → write at edge 2 → ts_valid=1 after edge 2, if the FIFO was empty.
  - Events closer together than 2 cycles may merge. This is not a requirement to handle.
- FIFO:
  - First-word-fall-through: ts_data shows the head entry whenever ts_valid=1.
  - ts_data is don't-care when ts_valid=0 and is not checked.
  - Pop occurs when ts_valid & ts_ready at a clk edge.
  - ts_valid and ts_data are stable while ts_valid=1 and ts_ready=0.
  - Pointers wrap modulo 2**DEPTH_LOG2; level tracks occupancy exactly.
- Push and pop in the same cycle:
  - Both take effect and level is unchanged.
  - When full, a push with a simultaneous pop is accepted (not dropped).
  - When empty, a push with ts_ready=1 writes normally; ts_valid rises the next cycle. There is no bypass.
- Full drop: a push while level=2**DEPTH_LOG2 with no pop discards the event, sets overflow=1, and increments drop_count (saturating at 255). The FIFO contents are unchanged.
- clear_overflow: sets overflow=0 and drop_count=0. If a drop occurs in the same cycle, the drop wins: overflow=1, drop_count=1.

Test Plan:
- Reset and prime: hold event_in=1 through reset, release rst, run 20 cycles → ts_valid stays 0, level=0, overflow=0.
- Single capture: counter_in increments by 1 each cycle from 1000; event_in rises when sampled at edge 0 → ts_valid=1 after edge 2, ts_data=1001 (value during detect cycle), level=1; one cycle of ts_ready=1 → level=0, ts_valid=0.
- Backpressure and fill: ts_ready=0; 16 rising edges spaced 4 cycles apart → level=16, overflow=0. Then 3 more edges → overflow=1, drop_count=3, and ts_data is still the first timestamp.
- Full with simultaneous push and pop: FIFO full, ts_ready=1 in the same cycle as a push → level stays 16, no drop, new timestamp becomes the last entry.
- EDGE_MODE=2 and clear: square wave with a 10-cycle period for 3 periods → 6 timestamps spaced 5 apart. Then clear_overflow coincident with a drop → overflow=1, drop_count=1.
- Reset mid-stream: level=5, assert rst for 1 cycle → level=0, ts_valid=0, drop_count=0; capture resumes only after the prime interval.
